// File: rtl/sh7604_mac_seq.sv
// sh7604_mac_seq: sequencer between the SH7604 decoder and the multiply/MAC unit.
// Takes one multiply-class command, issues the one or two register writes the
// unit needs, waits out a short guard window plus the unit's busy flag, then
// pulses DONE. STS reads come back on RES_DATA and are held until the next STS.
//
// Op map (MAC_OP encoding of the unit, 0000 added for STS):
//   two writes : 0001 MUL.L, 0010 DMULS.L, 0011 DMULU.L, 1001 MAC.L, 1011 MAC.W
//   one write  : 0100/0110/0111 MULx.W, 1000 LDS, 1111 CLRMAC
//   0000 STS, anything else completes without touching the unit.
module sh7604_mac_seq #(
    parameter int GUARD_CYC = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [3:0]  CMD_OP,
    input  logic [1:0]  CMD_SEL,
    input  logic        CMD_S,
    input  logic [31:0] CMD_A,
    input  logic [31:0] CMD_B,
    input  logic        CMD_HA,
    input  logic        CMD_HB,
    output logic [1:0]  M_SEL,
    output logic [3:0]  M_OP,
    output logic        M_S,
    output logic        M_WE,
    output logic [31:0] M_DI,
    output logic [31:0] M_A,
    input  logic [31:0] M_DO,
    input  logic        M_BUSY,
    output logic [31:0] RES_DATA,
    output logic        DONE
);

    localparam logic [3:0] OP_STS    = 4'b0000;
    localparam logic [3:0] OP_LDS    = 4'b1000;
    localparam logic [3:0] OP_CLRMAC = 4'b1111;
    localparam logic [3:0] OP_MACW   = 4'b1011;

    typedef enum logic [2:0] {S_IDLE, S_WRA, S_WRB, S_WR1, S_WAIT, S_READ} state_t;

    state_t      state_reg;
    logic        ready_reg;
    logic [1:0]  m_sel_reg;
    logic [3:0]  m_op_reg;
    logic        m_s_reg;
    logic        m_we_reg;
    logic [31:0] m_di_reg;
    logic [31:0] m_a_reg;
    logic [31:0] res_reg;
    logic        done_reg;
    logic [1:0]  guard_reg;
    // Fields still needed after the accept edge; the rest go straight into
    // the output registers on that edge.
    logic [31:0] b_reg;
    logic        hb_reg;

    function automatic logic is_two_write(input logic [3:0] op);
        return (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0011) ||
               (op == 4'b1001) || (op == 4'b1011);
    endfunction

    function automatic logic is_one_write(input logic [3:0] op);
        return (op == 4'b0100) || (op == 4'b1000) || (op == 4'b0110) ||
               (op == 4'b0111) || (op == 4'b1111);
    endfunction

    // Only MAC.W uses the address: bit1 picks the halfword of the operand.
    function automatic logic [31:0] mac_addr(input logic [3:0] op, input logic half);
        return (op == OP_MACW) ? {30'b0, half, 1'b0} : 32'b0;
    endfunction

    assign CMD_READY = ready_reg;
    assign M_SEL     = m_sel_reg;
    assign M_OP      = m_op_reg;
    assign M_S       = m_s_reg;
    assign M_WE      = m_we_reg;
    assign M_DI      = m_di_reg;
    assign M_A       = m_a_reg;
    assign RES_DATA  = res_reg;
    assign DONE      = done_reg;

    // Sequencer FSM with registered outputs; DONE self-clears every clock so
    // it stays a single-clock pulse even when CE_R is low afterwards.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= S_IDLE;
            ready_reg <= 1'b1;
            m_sel_reg <= 2'b00;
            m_op_reg  <= 4'b0000;
            m_s_reg   <= 1'b0;
            m_we_reg  <= 1'b0;
            m_di_reg  <= 32'b0;
            m_a_reg   <= 32'b0;
            res_reg   <= 32'b0;
            done_reg  <= 1'b0;
            guard_reg <= 2'b00;
            b_reg     <= 32'b0;
            hb_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (CE_R) begin
                case (state_reg)
                    S_IDLE: begin
                        if (CMD_VALID) begin
                            b_reg  <= CMD_B;
                            hb_reg <= CMD_HB;
                            if (is_two_write(CMD_OP)) begin
                                state_reg <= S_WRA;
                                ready_reg <= 1'b0;
                                m_we_reg  <= 1'b1;
                                m_sel_reg <= 2'b01;
                                m_op_reg  <= CMD_OP;
                                m_s_reg   <= CMD_S;
                                m_di_reg  <= CMD_A;
                                m_a_reg   <= mac_addr(CMD_OP, CMD_HA);
                            end else if (is_one_write(CMD_OP)) begin
                                state_reg <= S_WR1;
                                ready_reg <= 1'b0;
                                m_we_reg  <= 1'b1;
                                m_op_reg  <= CMD_OP;
                                m_s_reg   <= CMD_S;
                                m_a_reg   <= 32'b0;
                                if (CMD_OP == OP_LDS) begin
                                    m_sel_reg <= CMD_SEL;
                                    m_di_reg  <= CMD_A;
                                end else if (CMD_OP == OP_CLRMAC) begin
                                    m_sel_reg <= 2'b11;
                                    m_di_reg  <= 32'b0;
                                end else begin
                                    m_sel_reg <= 2'b10;
                                    m_di_reg  <= {CMD_B[15:0], CMD_A[15:0]};
                                end
                            end else if (CMD_OP == OP_STS) begin
                                state_reg <= S_READ;
                                ready_reg <= 1'b0;
                                m_sel_reg <= CMD_SEL;
                            end else begin
                                // Unknown op: complete at once, unit untouched.
                                done_reg <= 1'b1;
                            end
                        end
                    end
                    S_WRA: begin
                        state_reg <= S_WRB;
                        m_sel_reg <= 2'b10;
                        m_di_reg  <= b_reg;
                        m_a_reg   <= mac_addr(m_op_reg, hb_reg);
                    end
                    S_WRB, S_WR1: begin
                        state_reg <= S_WAIT;
                        m_we_reg  <= 1'b0;
                        m_sel_reg <= 2'b11;
                        m_op_reg  <= 4'b0000;
                        m_s_reg   <= 1'b0;
                        m_di_reg  <= 32'b0;
                        m_a_reg   <= 32'b0;
                        guard_reg <= 2'(GUARD_CYC);
                    end
                    S_WAIT: begin
                        // The unit may not have raised BUSY yet right after the
                        // last write, so the guard cycles ignore it.
                        if (guard_reg != 2'b00) begin
                            guard_reg <= guard_reg - 2'b01;
                        end else if (!M_BUSY) begin
                            state_reg <= S_IDLE;
                            ready_reg <= 1'b1;
                            m_sel_reg <= 2'b00;
                            done_reg  <= 1'b1;
                        end
                    end
                    S_READ: begin
                        if (!M_BUSY) begin
                            state_reg <= S_IDLE;
                            ready_reg <= 1'b1;
                            m_sel_reg <= 2'b00;
                            res_reg   <= M_DO;
                            done_reg  <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        ready_reg <= 1'b1;
                        m_sel_reg <= 2'b00;
                        m_we_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sh7604_mac_seq.sv
// tb_sh7604_mac_seq: directed bench for sh7604_mac_seq with a small behavioural
// multiply/MAC unit stub (MACH/MACL, programmable busy length).
module tb_sh7604_mac_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CE_R = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [3:0]  CMD_OP = 4'b0;
    logic [1:0]  CMD_SEL = 2'b0;
    logic        CMD_S = 1'b0;
    logic [31:0] CMD_A = 32'b0;
    logic [31:0] CMD_B = 32'b0;
    logic        CMD_HA = 1'b0;
    logic        CMD_HB = 1'b0;
    logic [1:0]  M_SEL;
    logic [3:0]  M_OP;
    logic        M_S;
    logic        M_WE;
    logic [31:0] M_DI;
    logic [31:0] M_A;
    logic [31:0] M_DO;
    logic        M_BUSY;
    logic [31:0] RES_DATA;
    logic        DONE;

    int checks = 0;
    int errors = 0;

    sh7604_mac_seq #(.GUARD_CYC(1)) dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
        .CMD_SEL(CMD_SEL), .CMD_S(CMD_S), .CMD_A(CMD_A), .CMD_B(CMD_B),
        .CMD_HA(CMD_HA), .CMD_HB(CMD_HB),
        .M_SEL(M_SEL), .M_OP(M_OP), .M_S(M_S), .M_WE(M_WE), .M_DI(M_DI),
        .M_A(M_A), .M_DO(M_DO), .M_BUSY(M_BUSY),
        .RES_DATA(RES_DATA), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // ---------------- multiply/MAC unit stub ----------------
    logic [31:0] mach = 32'b0;
    logic [31:0] macl = 32'b0;
    logic [31:0] opnd = 32'b0;
    int          busy_cnt = 0;
    int          busy_len = 2;

    function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] xs;
        logic signed [63:0] ys;
        xs = {{32{x[31]}}, x};
        ys = {{32{y[31]}}, y};
        return xs * ys;
    endfunction

    function automatic logic [31:0] half(input logic [31:0] d, input logic hi);
        logic [15:0] h;
        h = hi ? d[31:16] : d[15:0];
        return {{16{h[15]}}, h};
    endfunction

    assign M_BUSY = (busy_cnt != 0);
    assign M_DO   = (M_SEL == 2'b10) ? mach : (M_SEL == 2'b01) ? macl : 32'b0;

    always @(posedge CLK) begin
        if (RST) begin
            busy_cnt <= 0;
        end else if (CE_R) begin
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            if (M_WE) begin
                case (M_OP)
                    4'b0001: if (M_SEL == 2'b01) opnd <= M_DI;
                             else begin macl <= opnd * M_DI; busy_cnt <= busy_len; end
                    4'b0010: if (M_SEL == 2'b01) opnd <= M_DI;
                             else begin {mach, macl} <= smul(opnd, M_DI); busy_cnt <= busy_len; end
                    4'b1011: if (M_SEL == 2'b01) opnd <= half(M_DI, M_A[1]);
                             else begin
                                 {mach, macl} <= {mach, macl} + smul(opnd, half(M_DI, M_A[1]));
                                 busy_cnt <= busy_len;
                             end
                    4'b0100: begin
                                 macl <= smul(half(M_DI, 1'b0), half(M_DI, 1'b1)) & 64'hFFFF_FFFF;
                                 busy_cnt <= busy_len;
                             end
                    4'b1000: if (M_SEL == 2'b01) macl <= M_DI;
                             else if (M_SEL == 2'b10) mach <= M_DI;
                    4'b1111: begin mach <= 32'b0; macl <= 32'b0; end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] sel, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic ha, input logic hb);
        for (int n = 0; n < 20 && !CMD_READY; n++) step;
        check("ready_before_issue", {31'b0, CMD_READY}, 32'd1);
        CMD_OP = op; CMD_SEL = sel; CMD_S = s; CMD_A = a; CMD_B = b;
        CMD_HA = ha; CMD_HB = hb; CMD_VALID = 1'b1;
        step;
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !DONE; i++) step;
        check(tag, {31'b0, DONE}, 32'd1);
    endtask

    task automatic sts(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        issue(4'b0000, sel, 1'b0, 32'b0, 32'b0, 1'b0, 1'b0);
        wait_done({tag, "_done"}, 20);
        check(tag, RES_DATA, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int writes, dones, holds_bad, we_clocks, ready_bad, fall_cyc, done_cyc;
        logic we_b, ce, seen_busy;
        logic [1:0] sel_b;

        // ---- reset held 3 cycles with a command offered ----
        #1;
        CMD_VALID = 1'b1; CMD_OP = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step;
            check("rst_we", {31'b0, M_WE}, 32'd0);
            check("rst_done", {31'b0, DONE}, 32'd0);
        end
        CMD_VALID = 1'b0; RST = 1'b0;
        check("rst_ready", {31'b0, CMD_READY}, 32'd1);
        check("rst_sel", {30'b0, M_SEL}, 32'd0);
        check("rst_op", {28'b0, M_OP}, 32'd0);
        check("rst_s", {31'b0, M_S}, 32'd0);
        check("rst_di", M_DI, 32'd0);
        check("rst_a", M_A, 32'd0);
        check("rst_res", RES_DATA, 32'd0);

        // ---- DMULS.L -2 * 3 ----
        issue(4'b0010, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        check("dmuls_wra_we", {31'b0, M_WE}, 32'd1);
        check("dmuls_wra_sel", {30'b0, M_SEL}, 32'd1);
        check("dmuls_wra_di", M_DI, 32'hFFFF_FFFE);
        check("dmuls_wra_op", {28'b0, M_OP}, 32'd2);
        check("dmuls_ready_low", {31'b0, CMD_READY}, 32'd0);
        step;
        check("dmuls_wrb_we", {31'b0, M_WE}, 32'd1);
        check("dmuls_wrb_sel", {30'b0, M_SEL}, 32'd2);
        check("dmuls_wrb_di", M_DI, 32'd3);
        step;
        check("dmuls_wait_we", {31'b0, M_WE}, 32'd0);
        check("dmuls_wait_sel", {30'b0, M_SEL}, 32'd3);
        wait_done("dmuls_done", 20);
        step;
        check("dmuls_done_pulse", {31'b0, DONE}, 32'd0);
        sts("sts_mach_dmuls", 2'b10, 32'hFFFF_FFFF);
        sts("sts_macl_dmuls", 2'b01, 32'hFFFF_FFFA);

        // ---- CLRMAC then MAC.W (2 * 3) with S=1 ----
        issue(4'b1111, 2'b00, 1'b0, 32'b0, 32'b0, 1'b0, 1'b0);
        check("clrmac_we", {31'b0, M_WE}, 32'd1);
        check("clrmac_sel", {30'b0, M_SEL}, 32'd3);
        wait_done("clrmac_done", 20);
        issue(4'b1011, 2'b00, 1'b1, 32'h0002_0005, 32'h0007_0003, 1'b1, 1'b0);
        check("macw_wra_a", M_A, 32'd2);
        check("macw_wra_s", {31'b0, M_S}, 32'd1);
        check("macw_wra_di", M_DI, 32'h0002_0005);
        step;
        check("macw_wrb_a", M_A, 32'd0);
        check("macw_wrb_sel", {30'b0, M_SEL}, 32'd2);
        wait_done("macw_done", 20);
        sts("sts_macl_macw", 2'b01, 32'd6);

        // ---- LDS MACH and MULS.W ----
        issue(4'b1000, 2'b10, 1'b0, 32'h1234_5678, 32'b0, 1'b0, 1'b0);
        check("lds_sel", {30'b0, M_SEL}, 32'd2);
        check("lds_di", M_DI, 32'h1234_5678);
        wait_done("lds_done", 20);
        sts("sts_mach_lds", 2'b10, 32'h1234_5678);
        issue(4'b0100, 2'b00, 1'b0, 32'hFFFF_FFFD, 32'd4, 1'b0, 1'b0);
        check("mulsw_sel", {30'b0, M_SEL}, 32'd2);
        check("mulsw_di", M_DI, 32'h0004_FFFD);
        wait_done("mulsw_done", 20);
        sts("sts_macl_mulsw", 2'b01, 32'hFFFF_FFF4);

        // ---- MUL.L 7*9 with CE_R toggling 1/0 ----
        writes = 0; dones = 0; holds_bad = 0; we_clocks = 0;
        for (int i = 0; i < 40; i++) begin
            we_b = M_WE; sel_b = M_SEL;
            ce = (i % 2 == 0);
            CE_R = ce;
            if (i == 0) begin
                CMD_OP = 4'b0001; CMD_A = 32'd7; CMD_B = 32'd9; CMD_VALID = 1'b1;
            end
            step;
            CMD_VALID = 1'b0;
            if (we_b && ce) writes++;
            if (M_WE) we_clocks++;
            if (!ce && (M_SEL !== sel_b || M_WE !== we_b)) holds_bad++;
            if (DONE) dones++;
        end
        CE_R = 1'b1;
        check("ce_writes", writes, 32'd2);
        check("ce_we_clocks", we_clocks, 32'd4);
        check("ce_holds_bad", holds_bad, 32'd0);
        check("ce_dones", dones, 32'd1);
        sts("sts_macl_mull", 2'b01, 32'd63);

        // ---- busy held 10 cycles ----
        busy_len = 10;
        issue(4'b0001, 2'b00, 1'b0, 32'd2, 32'd5, 1'b0, 1'b0);
        ready_bad = 0; fall_cyc = -1; done_cyc = -1; seen_busy = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step;
            if (DONE) begin done_cyc = c; break; end
            if (CMD_READY) ready_bad++;
            if (M_BUSY) seen_busy = 1'b1;
            else if (seen_busy && fall_cyc < 0) fall_cyc = c;
        end
        check("busy_seen", {31'b0, seen_busy}, 32'd1);
        check("busy_ready_low", ready_bad, 32'd0);
        check("busy_done_after_fall", done_cyc, fall_cyc + 1);

        // ---- reset while in WAIT ----
        issue(4'b0001, 2'b00, 1'b0, 32'd3, 32'd3, 1'b0, 1'b0);
        step; step;
        check("rstw_in_wait", {30'b0, M_SEL}, 32'd3);
        RST = 1'b1;
        step;
        RST = 1'b0;
        check("rstw_ready", {31'b0, CMD_READY}, 32'd1);
        check("rstw_sel", {30'b0, M_SEL}, 32'd0);
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            if (DONE) dones++;
            step;
        end
        check("rstw_no_done", dones, 32'd0);
        busy_len = 2;

        // ---- unknown op 0101 ----
        issue(4'b0101, 2'b00, 1'b0, 32'd1, 32'd1, 1'b0, 1'b0);
        check("unk_done", {31'b0, DONE}, 32'd1);
        we_clocks = (M_WE ? 1 : 0);
        dones = 0;
        for (int c = 0; c < 3; c++) begin
            step;
            if (M_WE) we_clocks++;
            if (DONE) dones++;
        end
        check("unk_no_we", we_clocks, 32'd0);
        check("unk_single_done", dones, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
